// File: rtl/udp_pkg.sv
// Shared types and helpers for the UDP transmit packetizer.
package udp_pkg;

   localparam int MAX_UDP_PAYLOAD = 1472;

   typedef enum logic [2:0] {
      IDLE,
      START,
      SEND,
      WAIT_DONE,
      GAP
   } tx_state_e;

   // Saturating +1 for 16-bit event counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/udp_tx_packetizer_if.sv
// Byte-stream input and udp-core user TX port of the packetizer, bundled.
// master = the packetizer, slave = data source plus udp core.
interface udp_tx_packetizer_if;

   logic        din_en;
   logic [7:0]  din;
   logic        din_full;
   logic        tx_start_en;
   logic [15:0] tx_byte_num;
   logic        tx_req;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic [15:0] drop_cnt;
   logic        req_err;

   modport master (
      input  din_en, din, tx_req, tx_done,
      output din_full, tx_start_en, tx_byte_num, tx_data, drop_cnt, req_err
   );

   modport slave (
      output din_en, din, tx_req, tx_done,
      input  din_full, tx_start_en, tx_byte_num, tx_data, drop_cnt, req_err
   );

endinterface

// File: rtl/udp_tx_packetizer_fifo.sv
// Single-clock byte FIFO with registered read data and an occupancy count.
// A discard read pops a byte without updating the read data register.
module sync_fifo #(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   input  logic          rd_discard,
   output logic [7:0]    rd_data,
   output logic [AW:0]   count,
   output logic          full
);

   localparam int DEPTH = 1 << AW;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          wr_ok;
   logic          rd_ok;

   // Full is judged on the registered count, so a same-cycle read never frees room.
   always_comb begin
      wr_ok     = wr_en && !count_q[AW];
      rd_ok     = (rd_en || rd_discard) && (count_q != '0);
      wr_ptr_d  = wr_ptr_q + AW'(wr_ok);
      rd_ptr_d  = rd_ptr_q + AW'(rd_ok);
      count_d   = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      rd_data_d = (rd_en && rd_ok) ? mem_q[rd_ptr_q] : rd_data_q;
   end

   // Storage array; contents are not cleared, reset only empties the pointers.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // Pointer, count and read-data registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;
   assign count   = count_q;
   assign full    = count_q[AW];

endmodule

// File: rtl/udp_tx_packetizer.sv
// Buffers user bytes, cuts them into UDP payloads and drives the udp core TX port.
// One packet in flight; short packets are flushed after an idle timeout.
module udp_tx_packetizer
   import udp_pkg::*;
#(
   parameter int PKT_BYTES = 1024,
   parameter int FIFO_AW   = 11,
   parameter int FLUSH_CYC = 125000,
   parameter int IFG_CYC   = 16
) (
   input  logic                  gmii_tx_clk,
   input  logic                  rst,
   udp_tx_packetizer_if.master   bus
);

   localparam int FW = $clog2(FLUSH_CYC + 1);
   localparam int GW = $clog2(IFG_CYC + 1);
   localparam logic [FW-1:0]    FLUSH_LAST = FW'(FLUSH_CYC - 1);
   localparam logic [GW-1:0]    GAP_LAST   = GW'(IFG_CYC - 1);
   localparam logic [FIFO_AW:0] CNT_PKT    = (FIFO_AW+1)'(PKT_BYTES);

   tx_state_e        state_q, state_d;
   logic [FW-1:0]    flush_q, flush_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [15:0]      len_q, len_d;
   logic [15:0]      rem_q, rem_d;
   logic [15:0]      drop_q, drop_d;
   logic             start_q, start_d;
   logic             req_err_q, req_err_d;

   logic             wr;
   logic             pop_req;
   logic             pop_discard;
   logic [7:0]       fifo_rd_data;
   logic [FIFO_AW:0] fifo_count;
   logic             fifo_full;

   sync_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk        (gmii_tx_clk),
      .rst        (rst),
      .wr_en      (bus.din_en),
      .wr_data    (bus.din),
      .rd_en      (pop_req),
      .rd_discard (pop_discard),
      .rd_data    (fifo_rd_data),
      .count      (fifo_count),
      .full       (fifo_full)
   );

   // Next-state logic: packet cutting, core read handshake, abort discard and gap timing.
   always_comb begin
      state_d     = state_q;
      flush_d     = flush_q;
      gap_d       = gap_q;
      len_d       = len_q;
      rem_d       = rem_q;
      drop_d      = drop_q;
      start_d     = 1'b0;
      req_err_d   = req_err_q;
      pop_req     = 1'b0;
      pop_discard = 1'b0;
      wr          = bus.din_en && !fifo_full;

      if (bus.din_en && fifo_full) begin
         drop_d = sat_inc16(drop_q);
      end
      if (bus.tx_req && !(state_q == SEND && rem_q != '0)) begin
         req_err_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (wr || fifo_count == '0) begin
               flush_d = '0;
            end else begin
               flush_d = flush_q + 1'b1;
            end
            if (fifo_count >= CNT_PKT) begin
               len_d   = 16'(PKT_BYTES);
               start_d = 1'b1;
               flush_d = '0;
               state_d = START;
            end else if (flush_q == FLUSH_LAST && fifo_count != '0) begin
               len_d   = 16'(fifo_count);
               start_d = 1'b1;
               flush_d = '0;
               state_d = START;
            end
         end
         START: begin
            rem_d   = len_q;
            state_d = SEND;
         end
         SEND: begin
            if (bus.tx_req && rem_q != '0) begin
               pop_req = 1'b1;
               rem_d   = rem_q - 16'd1;
            end
            if (bus.tx_done) begin
               gap_d   = '0;
               state_d = GAP;
            end else if (rem_d == '0) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (bus.tx_done) begin
               gap_d   = '0;
               state_d = GAP;
            end
         end
         GAP: begin
            if (rem_q != '0) begin
               pop_discard = 1'b1;
               rem_d       = rem_q - 16'd1;
            end
            if (gap_q == GAP_LAST) begin
               if (rem_d == '0) begin
                  state_d = IDLE;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM and timer registers; every output of the block is registered here or in the FIFO.
   always_ff @(posedge gmii_tx_clk) begin
      if (rst) begin
         state_q   <= IDLE;
         flush_q   <= '0;
         gap_q     <= '0;
         len_q     <= '0;
         rem_q     <= '0;
         drop_q    <= '0;
         start_q   <= 1'b0;
         req_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         flush_q   <= flush_d;
         gap_q     <= gap_d;
         len_q     <= len_d;
         rem_q     <= rem_d;
         drop_q    <= drop_d;
         start_q   <= start_d;
         req_err_q <= req_err_d;
      end
   end

   assign bus.din_full    = fifo_full;
   assign bus.tx_start_en = start_q;
   assign bus.tx_byte_num = len_q;
   assign bus.tx_data     = fifo_rd_data;
   assign bus.drop_cnt    = drop_q;
   assign bus.req_err     = req_err_q;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Directed bench for udp_tx_packetizer with a scoreboard: writers push expected
// bytes/lengths, a monitor pops and compares whenever the DUT presents them.
module tb_udp_tx_packetizer;

   logic gmii_tx_clk = 1'b0;
   logic rst;

   int          tests_run    = 0;
   int          tests_failed = 0;
   int          cyc          = 0;
   logic [7:0]  data_q [$];
   int          len_q  [$];
   int          start_count  = 0;
   int          last_start_cyc = 0;
   int          done_count   = 0;
   int          done_cyc     = 0;
   int          last_wr_cyc  = 0;
   bit          core_en      = 1'b1;
   bit          kick         = 1'b0;
   bit          extra_req    = 1'b0;
   bit          core_parked  = 1'b0;
   int          stop_after   = 0;
   logic        req_in_pkt   = 1'b0;
   logic [7:0]  hold_val     = 8'h00;

   udp_tx_packetizer_if bus();

   udp_tx_packetizer #(
      .PKT_BYTES (8),
      .FIFO_AW   (4),
      .FLUSH_CYC (100),
      .IFG_CYC   (16)
   ) dut (
      .gmii_tx_clk (gmii_tx_clk),
      .rst         (rst),
      .bus         (bus)
   );

   // 125 MHz transmit clock.
   always #4 gmii_tx_clk = ~gmii_tx_clk;

   // Cycle index; read #1 after a rising edge it names the cycle now in progress.
   always @(posedge gmii_tx_clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Writes n consecutive bytes from first at one per cycle; the first 'accepted' are expected out.
   task automatic applyStimulus(input logic [7:0] first, input int n, input int accepted);
      for (int i = 0; i < n; i++) begin
         @(posedge gmii_tx_clk); #1;
         bus.din_en = 1'b1;
         bus.din    = first + 8'(i);
         if (i < accepted) data_q.push_back(first + 8'(i));
         last_wr_cyc = cyc;
      end
      @(posedge gmii_tx_clk); #1;
      bus.din_en = 1'b0;
   endtask

   task automatic waitDone(input int target, input int budget);
      int k = 0;
      while (done_count < target && k < budget) begin
         @(posedge gmii_tx_clk);
         k++;
      end
      tests_run++;
      if (done_count < target) begin
         tests_failed++;
         $display("[TB] FAIL wait_done: done_count %0d, expected %0d", done_count, target);
      end
   endtask

   // Model of the udp core: on a start pulse (or kick) it requests tx_byte_num bytes then pulses tx_done.
   initial begin : core_model
      int n;
      int limit;
      bus.tx_req  = 1'b0;
      bus.tx_done = 1'b0;
      forever begin
         @(posedge gmii_tx_clk);
         if (core_en && (bus.tx_start_en || kick) && !rst) begin
            n = int'(bus.tx_byte_num);
            #1;
            @(posedge gmii_tx_clk); #1;
            limit = (stop_after != 0) ? stop_after : n;
            for (int i = 0; i < limit; i++) begin
               bus.tx_req = 1'b1;
               req_in_pkt = 1'b1;
               @(posedge gmii_tx_clk); #1;
            end
            bus.tx_req = 1'b0;
            req_in_pkt = 1'b0;
            if (stop_after != 0) begin
               core_parked = 1'b1;
            end else begin
               if (extra_req) begin
                  bus.tx_req = 1'b1;
                  @(posedge gmii_tx_clk); #1;
                  bus.tx_req = 1'b0;
                  @(negedge gmii_tx_clk);
                  checkOutput("tx_data_held", 16'(bus.tx_data), 16'(hold_val));
                  checkOutput("req_err_set", 16'(bus.req_err), 16'd1);
                  @(posedge gmii_tx_clk); #1;
               end
               bus.tx_done = 1'b1;
               done_cyc = cyc;
               @(posedge gmii_tx_clk); #1;
               bus.tx_done = 1'b0;
               done_count++;
            end
         end
      end
   end

   // Scoreboard monitor: data one cycle after an in-packet tx_req, length on each start pulse.
   initial begin : monitor
      bit pend;
      pend = 1'b0;
      forever begin
         @(negedge gmii_tx_clk);
         if (rst) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               if (data_q.size() == 0) begin
                  tests_run++;
                  tests_failed++;
                  $display("[TB] FAIL tx_data_unexpected: got 0x%0h, expected no byte", bus.tx_data);
               end else begin
                  checkOutput("tx_data", 16'(bus.tx_data), 16'(data_q.pop_front()));
               end
            end
            pend = bus.tx_req && req_in_pkt;
            if (bus.tx_start_en) begin
               start_count++;
               last_start_cyc = cyc;
               if (len_q.size() == 0) begin
                  tests_run++;
                  tests_failed++;
                  $display("[TB] FAIL start_unexpected: got start with len %0d, expected none", bus.tx_byte_num);
               end else begin
                  checkOutput("tx_byte_num", bus.tx_byte_num, 16'(len_q.pop_front()));
               end
            end
         end
      end
   end

   // Hard stop if the sequence ever stalls.
   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int k;
      int sc;
      int d5;
      bus.din_en = 1'b0;
      bus.din    = 8'h00;
      rst        = 1'b1;
      repeat (3) @(posedge gmii_tx_clk);
      @(negedge gmii_tx_clk);
      checkOutput("rst_din_full",    16'(bus.din_full), 16'd0);
      checkOutput("rst_tx_start_en", 16'(bus.tx_start_en), 16'd0);
      checkOutput("rst_tx_byte_num", bus.tx_byte_num, 16'd0);
      checkOutput("rst_tx_data",     16'(bus.tx_data), 16'd0);
      checkOutput("rst_drop_cnt",    bus.drop_cnt, 16'd0);
      checkOutput("rst_req_err",     16'(bus.req_err), 16'd0);
      @(posedge gmii_tx_clk); #1;
      rst = 1'b0;

      // Full packet of 8 bytes.
      len_q.push_back(8);
      applyStimulus(8'h00, 8, 8);
      waitDone(1, 300);
      repeat (30) @(posedge gmii_tx_clk);

      // Short packet flushed by the idle timer: the write commits at the edge closing
      // cycle W, the pulse appears 100 edges later, i.e. in cycle W+101.
      len_q.push_back(3);
      applyStimulus(8'h10, 3, 3);
      waitDone(2, 400);
      checkOutput("flush_latency", 16'(last_start_cyc - last_wr_cyc), 16'd101);
      repeat (30) @(posedge gmii_tx_clk);

      // Overfill a 16-deep FIFO with no reads: 4 of 20 bytes dropped, both packets intact.
      core_en = 1'b0;
      len_q.push_back(8);
      applyStimulus(8'h40, 20, 16);
      @(negedge gmii_tx_clk);
      checkOutput("din_full_at_16", 16'(bus.din_full), 16'd1);
      checkOutput("drop_cnt_4", bus.drop_cnt, 16'd4);
      core_en = 1'b1;
      len_q.push_back(8);
      @(posedge gmii_tx_clk); #1;
      kick = 1'b1;
      @(posedge gmii_tx_clk); #1;
      kick = 1'b0;
      waitDone(4, 600);
      repeat (30) @(posedge gmii_tx_clk);

      // Writes keep flowing while the first packet is read out; second packet follows the gap.
      // Done in cycle D: GAP in D+1..D+16, IDLE in D+17, start pulse in D+18.
      len_q.push_back(8);
      len_q.push_back(8);
      applyStimulus(8'h80, 16, 16);
      waitDone(5, 400);
      d5 = done_cyc;
      waitDone(6, 400);
      checkOutput("ifg_spacing", 16'(last_start_cyc - d5), 16'd18);
      checkOutput("drop_cnt_steady", bus.drop_cnt, 16'd4);
      repeat (30) @(posedge gmii_tx_clk);

      // Ninth request beyond the packet: error flag, held data, FIFO untouched.
      checkOutput("req_err_clear", 16'(bus.req_err), 16'd0);
      extra_req = 1'b1;
      hold_val  = 8'hA7;
      len_q.push_back(8);
      applyStimulus(8'hA0, 8, 8);
      waitDone(7, 400);
      extra_req = 1'b0;
      repeat (30) @(posedge gmii_tx_clk);
      len_q.push_back(8);
      applyStimulus(8'hB0, 8, 8);
      waitDone(8, 400);
      repeat (30) @(posedge gmii_tx_clk);

      // Reset in the middle of a packet after three bytes.
      stop_after = 3;
      len_q.push_back(8);
      applyStimulus(8'hC0, 8, 8);
      k = 0;
      while (!core_parked && k < 300) begin
         @(posedge gmii_tx_clk);
         k++;
      end
      checkOutput("abort_point_reached", 16'(core_parked), 16'd1);
      @(negedge gmii_tx_clk);
      @(posedge gmii_tx_clk); #1;
      rst         = 1'b1;
      stop_after  = 0;
      core_parked = 1'b0;
      @(posedge gmii_tx_clk);
      @(negedge gmii_tx_clk);
      checkOutput("mid_rst_din_full",    16'(bus.din_full), 16'd0);
      checkOutput("mid_rst_tx_start_en", 16'(bus.tx_start_en), 16'd0);
      checkOutput("mid_rst_tx_byte_num", bus.tx_byte_num, 16'd0);
      checkOutput("mid_rst_tx_data",     16'(bus.tx_data), 16'd0);
      checkOutput("mid_rst_drop_cnt",    bus.drop_cnt, 16'd0);
      checkOutput("mid_rst_req_err",     16'(bus.req_err), 16'd0);
      data_q.delete();
      len_q.delete();
      @(posedge gmii_tx_clk); #1;
      rst = 1'b0;
      sc  = start_count;
      repeat (300) @(posedge gmii_tx_clk);
      @(negedge gmii_tx_clk);
      checkOutput("no_start_after_rst", 16'(start_count - sc), 16'd0);

      // Fresh packet after reset starts from an empty FIFO.
      len_q.push_back(8);
      applyStimulus(8'hD0, 8, 8);
      waitDone(9, 400);
      repeat (20) @(posedge gmii_tx_clk);
      @(negedge gmii_tx_clk);
      checkOutput("data_queue_drained", 16'(data_q.size()), 16'd0);
      checkOutput("len_queue_drained", 16'(len_q.size()), 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
